fetch_unit: RTL and testbench

//  Parametrised, decoupled instruction fetch stage: PC, req/gnt/rvalid memory port, in-order prefetch queue, valid/ready decode port.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_if.sv | 47 ++++
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and helpers for the decoupled instruction fetch
//             stage: FSM state encoding, default-width queue entry and the
//             occupancy-counter width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,   // normal fetching
        DRAIN = 2'd1,   // discarding responses to pre-redirect requests
        HALT  = 2'd2    // hlt asserted and nothing outstanding
    } fetch_state_t;

    localparam int C_ADDR_W  = 16;
    localparam int C_INSTR_W = 16;

    // Queue entry at the default widths; parameterised modules rebuild the
    // same layout locally at their own widths.
    typedef struct packed {
        logic [C_ADDR_W-1:0]  pc;
        logic [C_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Width needed to hold a count in the range 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_if
//  Purpose  : Bundles the fetch stage's memory port, redirect/halt controls
//             and decode port.
//  Signals  : imem_req/imem_addr/imem_gnt        request handshake
//             imem_rvalid/imem_rdata             in-order read responses
//             redirect_valid/redirect_addr, hlt  control from the core
//             dec_valid/dec_ready/dec_instr/dec_pc/dec_pc_inc  decode port
//  Modports : master = fetch unit, slave = memory + core environment
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               hlt;
    logic               dec_valid;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
    logic [ADDR_W-1:0]  dec_pc_inc;
    logic               dec_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_addr, hlt,
        output dec_valid, dec_instr, dec_pc, dec_pc_inc,
        input  dec_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_addr, hlt,
        input  dec_valid, dec_instr, dec_pc, dec_pc_inc,
        output dec_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Synchronous FIFO holding fetched {pc, instr} entries in order.
//  Ports    : clk, rst            clock, sync active-high reset
//             push, push_data     write an entry (never while full)
//             pop                 remove head (never while empty)
//             flush               discard all entries
//             count, head         occupancy and head entry
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    input  wire logic             flush,
    output logic      [CW-1:0]    count,
    output logic      [WIDTH-1:0] head
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Decoupled instruction fetch stage. Issues word-addressed
//             requests under a credit limit, queues in-order responses with
//             their PC, presents them on a valid/ready decode port, flushes
//             and drains stale responses on redirect, and stops issuing on hlt.
//  Ports    : clk, rst     clock, synchronous active-high reset
//             bus          fetch_if.master (memory, control, decode signals)
//             perf_issued  granted requests
//             perf_dropped discarded responses
//             perf_stall   RUN cycles with hlt low and no credit
//  Config   : FETCH_PERF_EN - when defined the perf counters are built;
//             otherwise the perf_* outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                INSTR_W    = 16,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fetch_if.master          bus,
    output logic      [31:0] perf_issued,
    output logic      [31:0] perf_dropped,
    output logic      [31:0] perf_stall
);
    localparam int          CW      = cnt_width(DEPTH);
    localparam logic [CW:0] C_DEPTH = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [CW-1:0]     r_in_flight;
    logic [CW-1:0]     r_drop_cnt;
    logic [CW-1:0]     w_q_count;
    logic [CW-1:0]     w_outstanding;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_gnt;
    logic              w_drop;
    logic              w_accept;
    logic              w_pop;
    entry_t            w_push_entry;
    entry_t            w_head;

    // Queued plus outstanding entries may never exceed DEPTH, so a response
    // always finds room in the queue.
    assign w_credit_ok = ({1'b0, w_q_count} + {1'b0, r_in_flight}) < C_DEPTH;
    assign w_issue     = !rst && (r_state == RUN) && !bus.hlt
                         && !bus.redirect_valid && w_credit_ok;
    assign w_gnt       = w_issue && bus.imem_gnt;

    // A response is stale if it belongs to a request issued before the
    // latest redirect, including one that returns in the redirect cycle.
    assign w_drop   = bus.imem_rvalid && (bus.redirect_valid || (r_drop_cnt != '0));
    assign w_accept = bus.imem_rvalid && !w_drop;
    assign w_pop    = bus.dec_valid && bus.dec_ready;

    // Outstanding requests after this edge; on a redirect every one of them
    // is stale.
    assign w_outstanding = r_in_flight + CW'(w_gnt) - CW'(bus.imem_rvalid);

    assign w_push_entry = '{pc: r_resp_pc, instr: bus.imem_rdata};

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W),
        .CW    (CW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (w_accept),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (bus.redirect_valid),
        .count     (w_q_count),
        .head      (w_head)
    );

    assign bus.imem_req   = w_issue;
    assign bus.imem_addr  = r_fetch_pc;
    assign bus.dec_valid  = (w_q_count != '0);
    assign bus.dec_instr  = w_head.instr;
    assign bus.dec_pc     = w_head.pc;
    assign bus.dec_pc_inc = w_head.pc + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect_valid) begin
            w_state_nxt = (w_outstanding != '0) ? DRAIN : RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.hlt && (r_in_flight == '0)) w_state_nxt = HALT;
                end
                DRAIN: begin
                    if (bus.imem_rvalid && (r_drop_cnt == CW'(1))) begin
                        w_state_nxt = bus.hlt ? HALT : RUN;
                    end
                end
                HALT: begin
                    if (!bus.hlt) w_state_nxt = RUN;
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_ADDR;
            r_resp_pc   <= RESET_ADDR;
            r_in_flight <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_in_flight <= w_outstanding;
            if (bus.redirect_valid) begin
                r_fetch_pc <= bus.redirect_addr;
                r_resp_pc  <= bus.redirect_addr;
                r_drop_cnt <= w_outstanding;
            end else begin
                if (w_gnt)    r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                if (w_accept) r_resp_pc  <= r_resp_pc + ADDR_W'(1);
                if (w_drop)   r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic        w_stall;
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_dropped;
    logic [31:0] r_perf_stall;

    assign w_stall = (r_state == RUN) && !bus.hlt && !w_credit_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_issued  <= '0;
            r_perf_dropped <= '0;
            r_perf_stall   <= '0;
        end else begin
            r_perf_issued  <= r_perf_issued  + 32'(w_gnt);
            r_perf_dropped <= r_perf_dropped + 32'(w_drop);
            r_perf_stall   <= r_perf_stall   + 32'(w_stall);
        end
    end

    assign perf_issued  = r_perf_issued;
    assign perf_dropped = r_perf_dropped;
    assign perf_stall   = r_perf_stall;
`else
    assign perf_issued  = '0;
    assign perf_dropped = '0;
    assign perf_stall   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. A memory model with
//             programmable latency and grant enable answers requests; a
//             scoreboard of expected decode PCs is rebuilt on reset and
//             redirect and consumed on every decode handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int AW    = 16;
    localparam int IW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    logic [31:0] perf_issued;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;

    fetch_unit #(
        .ADDR_W     (AW),
        .INSTR_W    (IW),
        .DEPTH      (DEPTH),
        .RESET_ADDR (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .perf_issued  (perf_issued),
        .perf_dropped (perf_dropped),
        .perf_stall   (perf_stall)
    );

    int checks = 0;
    int errors = 0;

    logic gnt_en  = 1'b1;
    int   lat     = 1;
    int   cyc     = 0;
    int   pop_cnt = 0;
    logic prev_redirect = 1'b0;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    pend_t         pend_q[$];
    logic [AW-1:0] sb_q[$];

    assign bus.imem_gnt = gnt_en;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_restart(input logic [AW-1:0] start);
        sb_q.delete();
        for (int i = 0; i < 128; i++) sb_q.push_back(start + AW'(i));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory response side: one in-order response per cycle once due.
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = '0;
            end
        end
    end

    // Mid-cycle monitor: records grants and scores decode handshakes.
    initial begin
        logic [AW-1:0] exp_pc;
        logic [AW-1:0] exp_inc;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_q.delete();
                sb_restart(16'h0000);
                prev_redirect = 1'b0;
            end else begin
                if (bus.imem_req && bus.imem_gnt) begin
                    pend_q.push_back('{addr: bus.imem_addr, due: cyc + lat});
                end
                if (prev_redirect) chk("dec_valid_after_redirect", 32'(bus.dec_valid), 32'd0);
                if (bus.dec_valid && bus.dec_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL sb_underflow: observed pc 0x%0h expected none", bus.dec_pc);
                    end else begin
                        exp_pc  = sb_q.pop_front();
                        exp_inc = exp_pc + 16'd1;
                        chk("dec_pc", 32'(bus.dec_pc), 32'(exp_pc));
                        chk("dec_instr", 32'(bus.dec_instr), 32'(mem_word(exp_pc)));
                        chk("dec_pc_inc", 32'(bus.dec_pc_inc), 32'(exp_inc));
                    end
                    pop_cnt++;
                end
                if (bus.redirect_valid) sb_restart(bus.redirect_addr);
                prev_redirect = bus.redirect_valid;
            end
        end
    end

    initial begin
        int            p;
        logic [31:0]   d0;
        logic [AW-1:0] nxt;

        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.hlt            = 1'b0;
        bus.dec_ready      = 1'b1;

        // Reset state
        step(2);
        @(negedge clk);
        chk("reset_imem_req", 32'(bus.imem_req), 32'd0);
        chk("reset_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("reset_state", 32'(dut.r_state), 32'(RUN));
        chk("reset_perf_issued", perf_issued, 32'd0);
        chk("reset_perf_dropped", perf_dropped, 32'd0);
        chk("reset_perf_stall", perf_stall, 32'd0);

        // 1-cycle memory, full throughput after fill
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", 32'(bus.imem_addr), 32'h0000);
        step(2);
        chk("pops_before_fill", 32'(pop_cnt), 32'd0);
        p = pop_cnt;
        step(10);
        chk("pops_per_cycle", 32'(pop_cnt - p), 32'd10);

        // Decode backpressure fills the queue and exhausts credit
        bus.dec_ready = 1'b0;
        step(10);
        @(negedge clk);
        chk("stall_q_count", 32'(dut.u_queue.r_count), 32'd4);
        chk("stall_in_flight", 32'(dut.r_in_flight), 32'd0);
        chk("stall_imem_req", 32'(bus.imem_req), 32'd0);
        chk("stall_head_pc", 32'(bus.dec_pc), 32'(sb_q[0]));
`ifdef FETCH_PERF_EN
        chk("stall_perf_counted", 32'(perf_stall != 32'd0), 32'd1);
`endif
        step(1);
        bus.dec_ready = 1'b1;
        step(8);

        // Latency 3, redirect with exactly two requests in flight
        gnt_en = 1'b0;
        lat    = 3;
        step(8);
        @(negedge clk);
        chk("idle_in_flight", 32'(dut.r_in_flight), 32'd0);
        chk("idle_dec_valid", 32'(bus.dec_valid), 32'd0);
        step(1);
        gnt_en = 1'b1;
        step(2);
        gnt_en = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 16'h0040;
        @(negedge clk);
        chk("redir3_in_flight", 32'(dut.r_in_flight), 32'd2);
        d0 = perf_dropped;
        step(1);
        bus.redirect_valid = 1'b0;
        gnt_en = 1'b1;
        @(negedge clk);
        chk("drain_state", 32'(dut.r_state), 32'(DRAIN));
        chk("drain_req_a", 32'(bus.imem_req), 32'd0);
        step(1);
        @(negedge clk);
        chk("drain_req_b", 32'(bus.imem_req), 32'd0);
        step(1);
        @(negedge clk);
        chk("redir3_req", 32'(bus.imem_req), 32'd1);
        chk("redir3_addr", 32'(bus.imem_addr), 32'h0040);
`ifdef FETCH_PERF_EN
        chk("redir3_perf_dropped", perf_dropped - d0, 32'd2);
`else
        chk("redir3_perf_dropped", perf_dropped, 32'd0);
`endif
        step(12);

        // Redirect in the same cycle as a returning response
        gnt_en = 1'b0;
        step(6);
        lat    = 1;
        gnt_en = 1'b1;
        step(6);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 16'h0100;
        @(negedge clk);
        chk("redir1_rvalid", 32'(bus.imem_rvalid), 32'd1);
        chk("redir1_in_flight", 32'(dut.r_in_flight), 32'd1);
        d0 = perf_dropped;
        step(1);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir1_req", 32'(bus.imem_req), 32'd1);
        chk("redir1_addr", 32'(bus.imem_addr), 32'h0100);
`ifdef FETCH_PERF_EN
        chk("redir1_perf_dropped", perf_dropped - d0, 32'd1);
`else
        chk("redir1_perf_dropped", perf_dropped, 32'd0);
`endif
        step(8);

        // hlt with two in flight: both delivered, then halted
        gnt_en = 1'b0;
        lat    = 3;
        step(8);
        gnt_en = 1'b1;
        step(2);
        bus.hlt = 1'b1;
        p = pop_cnt;
        @(negedge clk);
        chk("hlt_in_flight", 32'(dut.r_in_flight), 32'd2);
        chk("hlt_no_req", 32'(bus.imem_req), 32'd0);
        step(8);
        @(negedge clk);
        chk("hlt_delivered", 32'(pop_cnt - p), 32'd2);
        chk("hlt_state", 32'(dut.r_state), 32'(HALT));
        chk("hlt_req_low", 32'(bus.imem_req), 32'd0);
        nxt = sb_q[0];
        step(1);
        bus.hlt = 1'b0;
        step(1);
        @(negedge clk);
        chk("resume_req", 32'(bus.imem_req), 32'd1);
        chk("resume_addr", 32'(bus.imem_addr), 32'(nxt));
        step(10);

        // Address wrap through 0xFFFF
        gnt_en = 1'b0;
        step(6);
        lat    = 1;
        gnt_en = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 16'hFFFE;
        p = pop_cnt;
        step(1);
        bus.redirect_valid = 1'b0;
        step(9);
        chk("wrap_pops", 32'(pop_cnt - p), 32'd7);

        // Reset in the middle of a burst
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", 32'(bus.imem_req), 32'd0);
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("midrst_req_after", 32'(bus.imem_req), 32'd1);
        chk("midrst_addr", 32'(bus.imem_addr), 32'h0000);
        chk("midrst_perf_issued", perf_issued, 32'd0);
        step(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
